// File: rtl/sticky_pkg.sv
// Shared types and helpers for the sticky flag bank.
package sticky_pkg;

  // Per-channel state; encodings are fixed so they read sensibly in waveforms.
  typedef enum logic [1:0] {
    StDisarmed = 2'd0,
    StArmed    = 2'd1,
    StQual     = 2'd2,
    StLatched  = 2'd3
  } chan_state_e;

  // Debounce run counter width, large enough for DEBOUNCE up to 15.
  localparam int unsigned RunW = 4;

  // Widest event counter supported; the helper works at this width.
  localparam int unsigned MaxCntW = 16;

  // Increment val, holding at the all-ones value of a width-bit counter.
  function automatic logic [MaxCntW-1:0] sat_inc(input logic [MaxCntW-1:0] val,
                                                  input int unsigned       width);
    logic [MaxCntW:0] lim;
    lim = (17'd1 << width) - 17'd1;
    if ({1'b0, val} >= lim) begin
      return val;
    end
    return val + 16'd1;
  endfunction

endpackage

// File: rtl/sticky_chan.sv
// One sticky event channel: qualification FSM, debounce run counter,
// previous-sample register and saturating event counter.
module sticky_chan
  import sticky_pkg::*;
#(
  parameter int unsigned DEBOUNCE  = 1,
  parameter int unsigned EDGE_MODE = 0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arm,
  input  logic             clear,
  input  logic             clr_ch,
  input  logic             in,
  input  logic             mask,
  output logic             flag,
  output logic             latch_now,
  output logic [CNT_W-1:0] evt_cnt
);

  // Edge mode and single-cycle debounce skip the QUAL state entirely.
  localparam bit          Instant = (EDGE_MODE != 0) || (DEBOUNCE <= 1);
  localparam logic [RunW:0] DebLim = (RunW + 1)'(DEBOUNCE);

  chan_state_e      state_q, state_d;
  logic [RunW-1:0]  run_q, run_d;
  logic             in_d_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;
  logic             qual;

  // Qualifying sample selection: unmasked rising edge or unmasked level.
  always_comb begin
    rise = in & ~in_d_q & ~mask;
    qual = (EDGE_MODE != 0) ? rise : (in & ~mask);
  end

  // Next-state: clear beats clr_ch beats arm beats qualification.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (clear) begin
      state_d = StDisarmed;
      run_d   = '0;
    end else if (clr_ch) begin
      state_d = StArmed;
      run_d   = '0;
    end else begin
      case (state_q)
        StDisarmed: begin
          if (arm) state_d = StArmed;
        end
        StArmed: begin
          if (qual) begin
            if (Instant) begin
              state_d = StLatched;
            end else begin
              state_d = StQual;
              run_d   = RunW'(1);
            end
          end
        end
        StQual: begin
          if (qual) begin
            if (({1'b0, run_q} + 5'd1) >= DebLim) begin
              state_d = StLatched;
              run_d   = '0;
            end else begin
              run_d = run_q + RunW'(1);
            end
          end else begin
            // Any break in the run, masking included, restarts debounce.
            state_d = StArmed;
            run_d   = '0;
          end
        end
        StLatched: begin
          state_d = StLatched;
        end
        default: begin
          state_d = StDisarmed;
          run_d   = '0;
        end
      endcase
    end
  end

  // One-cycle pulse on entry to LATCHED; never asserted under clear.
  always_comb begin
    latch_now = (state_d == StLatched) && (state_q != StLatched);
  end

  // Event counter: counts unmasked rising edges while not disarmed, saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (rise && (state_q != StDisarmed)) begin
      cnt_d = CNT_W'(sat_inc(MaxCntW'(cnt_q), CNT_W));
    end
  end

  // State, run count, previous input and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StDisarmed;
      run_q   <= '0;
      in_d_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      in_d_q  <= in;
      cnt_q   <= cnt_d;
    end
  end

  assign flag    = (state_q == StLatched);
  assign evt_cnt = cnt_q;

endmodule

// File: rtl/sticky_flag_bank.sv
// Multi-channel sticky event latch with first-to-fire capture across the bank.
module sticky_flag_bank
  import sticky_pkg::*;
#(
  parameter int unsigned NCH       = 8,
  parameter int unsigned DEBOUNCE  = 1,
  parameter int unsigned EDGE_MODE = 0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  arm,
  input  logic                                  clear,
  input  logic [NCH-1:0]                        clr_ch,
  input  logic [NCH-1:0]                        in,
  input  logic [NCH-1:0]                        mask,
  output logic [NCH-1:0]                        flag,
  output logic                                  any_flag,
  output logic                                  first_valid,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] first_idx,
  output logic [NCH*CNT_W-1:0]                  evt_cnt
);

  localparam int unsigned IdxW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]  latch_now;
  logic [IdxW-1:0] enc_idx;
  logic            any_flag_q, any_flag_d;
  logic            first_valid_q, first_valid_d;
  logic [IdxW-1:0] first_idx_q, first_idx_d;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    sticky_chan #(
      .DEBOUNCE  (DEBOUNCE),
      .EDGE_MODE (EDGE_MODE),
      .CNT_W     (CNT_W)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .arm       (arm),
      .clear     (clear),
      .clr_ch    (clr_ch[i]),
      .in        (in[i]),
      .mask      (mask[i]),
      .flag      (flag[i]),
      .latch_now (latch_now[i]),
      .evt_cnt   (evt_cnt[i*CNT_W +: CNT_W])
    );
  end

  // Lowest-index priority encoder over this cycle's latch events.
  always_comb begin
    enc_idx = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (latch_now[i]) enc_idx = IdxW'(i);
    end
  end

  // any_flag tracks the flags' next value so it moves on the same edge.
  always_comb begin
    any_flag_d = ~clear & (|((flag & ~clr_ch) | latch_now));
  end

  // First capture loads once per clear/reset interval; clr_ch leaves it alone.
  always_comb begin
    first_valid_d = first_valid_q;
    first_idx_d   = first_idx_q;
    if (clear) begin
      first_valid_d = 1'b0;
      first_idx_d   = '0;
    end else if (!first_valid_q && (|latch_now)) begin
      first_valid_d = 1'b1;
      first_idx_d   = enc_idx;
    end
  end

  // Bank-level status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      any_flag_q    <= 1'b0;
      first_valid_q <= 1'b0;
      first_idx_q   <= '0;
    end else begin
      any_flag_q    <= any_flag_d;
      first_valid_q <= first_valid_d;
      first_idx_q   <= first_idx_d;
    end
  end

  assign any_flag    = any_flag_q;
  assign first_valid = first_valid_q;
  assign first_idx   = first_idx_q;

endmodule
